demux_stream: RTL and testbench

- Parametrised, registered stream demultiplexer; successor to the fixed 1x8 combinational demux.
- Routes a valid/ready data stream to one of NB_OUT output channels, or to all of them in broadcast mode.
- Each output channel has a one-entry register slot, giving full throughput per channel.
- Packet-lock mode holds the route for a whole multi-beat packet; beats addressed to nonexistent channels are dropped and counted.
- Sits between a single producer and NB_OUT consumer blocks in the routing library.

---
 rtl/demux_stream.sv | 122 ++++++++++++
 tb/tb_demux_stream.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream.sv
// Registered valid/ready stream demultiplexer with per-channel one-entry slots,
// broadcast, packet-lock routing and a saturating counter of dropped beats.
module demux_stream #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NB_OUT = 8,
    parameter int unsigned SEL_W  = 3,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    bcast,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    in_last,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [NB_OUT*WIDTH-1:0] out_data,
    output logic [NB_OUT-1:0]       out_last,
    output logic [NB_OUT-1:0]       out_valid,
    input  logic [NB_OUT-1:0]       out_ready,
    output logic                    busy,
    output logic [SEL_W-1:0]        cur_sel,
    output logic [CNT_W-1:0]        drop_cnt
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state, state_next;
    logic [SEL_W-1:0] cur_sel_next;
    logic             cur_bcast, cur_bcast_next;

    logic [SEL_W-1:0]  eff_sel;
    logic              eff_bcast;
    logic              valid_tgt;
    logic [NB_OUT-1:0] tgt;
    logic [NB_OUT-1:0] free;
    logic [NB_OUT-1:0] load;
    logic              accept;
    logic              drop;

    // Route selection: live inputs in IDLE, latched route while a packet is locked.
    always_comb begin
        eff_sel   = (state == IDLE) ? sel : cur_sel;
        eff_bcast = (state == IDLE) ? bcast : cur_bcast;
        valid_tgt = 32'(eff_sel) < NB_OUT;
        for (int unsigned i = 0; i < NB_OUT; i++) begin
            tgt[i] = eff_bcast || (eff_sel == SEL_W'(i));
        end
        free = ~out_valid | out_ready;
        if (eff_bcast) begin
            in_ready = &free;
        end else if (valid_tgt) begin
            in_ready = |(free & tgt);
        end else begin
            in_ready = 1'b1;
        end
        accept = in_valid && in_ready;
        load   = {NB_OUT{accept}} & tgt;
        drop   = accept && !eff_bcast && !valid_tgt;
    end

    always_comb begin
        state_next     = state;
        cur_sel_next   = cur_sel;
        cur_bcast_next = cur_bcast;
        case (state)
            IDLE: begin
                if (accept && !in_last) begin
                    state_next     = LOCKED;
                    cur_sel_next   = sel;
                    cur_bcast_next = bcast;
                end
            end
            LOCKED: begin
                if (accept && in_last) begin
                    state_next     = IDLE;
                    cur_sel_next   = '0;
                    cur_bcast_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cur_sel   <= '0;
            cur_bcast <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            state     <= state_next;
            cur_sel   <= cur_sel_next;
            cur_bcast <= cur_bcast_next;
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

    // Output slots: reload and drain may coincide, giving one beat per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= '0;
            out_data  <= '0;
            out_last  <= '0;
        end else begin
            for (int unsigned i = 0; i < NB_OUT; i++) begin
                if (load[i]) begin
                    out_valid[i]                <= 1'b1;
                    out_data[i*WIDTH +: WIDTH]  <= in_data;
                    out_last[i]                 <= in_last;
                end else if (out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign busy = (state == LOCKED);

endmodule

// File: tb/tb_demux_stream.sv
// Directed bench for demux_stream: an 8-channel instance for routing behaviour
// and a 6-channel instance for dropped-beat handling.
module tb_demux_stream;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [2:0]  sel;
    logic        bcast;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_data;
    logic [7:0]  out_last;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic        busy;
    logic [2:0]  cur_sel;
    logic [7:0]  drop_cnt;

    logic [2:0]  b_sel;
    logic        b_bcast;
    logic [7:0]  b_in_data;
    logic        b_in_last;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [47:0] b_out_data;
    logic [5:0]  b_out_last;
    logic [5:0]  b_out_valid;
    logic [5:0]  b_out_ready;
    logic        b_busy;
    logic [2:0]  b_cur_sel;
    logic [7:0]  b_drop_cnt;

    int tests = 0;
    int fails = 0;

    demux_stream #(.WIDTH(8), .NB_OUT(8), .SEL_W(3), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .sel(sel), .bcast(bcast),
        .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .cur_sel(cur_sel), .drop_cnt(drop_cnt)
    );

    demux_stream #(.WIDTH(8), .NB_OUT(6), .SEL_W(3), .CNT_W(8)) u_dut6 (
        .clk(clk), .reset(reset), .sel(b_sel), .bcast(b_bcast),
        .in_data(b_in_data), .in_last(b_in_last), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_last(b_out_last), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .busy(b_busy), .cur_sel(b_cur_sel), .drop_cnt(b_drop_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        sel = '0; bcast = 1'b0; in_data = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 8'hFF;
        b_sel = 3'd7; b_bcast = 1'b0; b_in_data = '0; b_in_last = 1'b1; b_in_valid = 1'b0;
        b_out_ready = 6'h3F;
        step(); step();
        reset = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_out_last", 64'(out_last), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_cur_sel", 64'(cur_sel), 64'h0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'h0);

        // Unicast single beat to channel 5
        sel = 3'd5; in_data = 8'hA5; in_last = 1'b1; in_valid = 1'b1;
        #1 chk("uni_in_ready", 64'(in_ready), 64'h1);
        step();
        in_valid = 1'b0;
        chk("uni_out_valid", 64'(out_valid), 64'h20);
        chk("uni_out_data", 64'(out_data[47:40]), 64'hA5);
        chk("uni_out_last", 64'(out_last[5]), 64'h1);
        chk("uni_busy", 64'(busy), 64'h0);
        step();
        chk("uni_drained", 64'(out_valid), 64'h0);

        // Three-beat packet locked to channel 2 despite sel changing
        sel = 3'd2; in_data = 8'h11; in_last = 1'b0; in_valid = 1'b1;
        step();
        chk("lock_b0_valid", 64'(out_valid), 64'h04);
        chk("lock_b0_data", 64'(out_data[23:16]), 64'h11);
        chk("lock_b0_busy", 64'(busy), 64'h1);
        chk("lock_b0_cur_sel", 64'(cur_sel), 64'h2);
        sel = 3'd6; in_data = 8'h22;
        step();
        chk("lock_b1_valid", 64'(out_valid), 64'h04);
        chk("lock_b1_data", 64'(out_data[23:16]), 64'h22);
        chk("lock_b1_busy", 64'(busy), 64'h1);
        in_data = 8'h33; in_last = 1'b1;
        step();
        in_valid = 1'b0;
        chk("lock_b2_valid", 64'(out_valid), 64'h04);
        chk("lock_b2_data", 64'(out_data[23:16]), 64'h33);
        chk("lock_b2_last", 64'(out_last[2]), 64'h1);
        chk("lock_b2_busy", 64'(busy), 64'h0);
        chk("lock_b2_cur_sel", 64'(cur_sel), 64'h0);
        step();
        chk("lock_drained", 64'(out_valid), 64'h0);

        // Backpressure on channel 3
        out_ready = 8'hF7;
        sel = 3'd3; in_data = 8'h44; in_last = 1'b1; in_valid = 1'b1;
        #1 chk("bp_a_ready", 64'(in_ready), 64'h1);
        step();
        in_data = 8'h55;
        chk("bp_b_blocked", 64'(in_ready), 64'h0);
        step();
        chk("bp_hold_valid", 64'(out_valid), 64'h08);
        chk("bp_hold_data", 64'(out_data[31:24]), 64'h44);
        step();
        chk("bp_hold_data2", 64'(out_data[31:24]), 64'h44);
        chk("bp_still_blocked", 64'(in_ready), 64'h0);
        out_ready = 8'hFF;
        #1 chk("bp_release_ready", 64'(in_ready), 64'h1);
        step();
        in_valid = 1'b0;
        chk("bp_b_valid", 64'(out_valid), 64'h08);
        chk("bp_b_data", 64'(out_data[31:24]), 64'h55);
        step();
        chk("bp_drained", 64'(out_valid), 64'h0);

        // Broadcast waits for every slot to be free
        out_ready = 8'hFD;
        sel = 3'd1; in_data = 8'h66; in_last = 1'b1; in_valid = 1'b1;
        step();
        bcast = 1'b1; in_data = 8'h77;
        #1 chk("bc_blocked", 64'(in_ready), 64'h0);
        step();
        chk("bc_slot1_valid", 64'(out_valid), 64'h02);
        chk("bc_slot1_data", 64'(out_data[15:8]), 64'h66);
        out_ready = 8'hFF;
        #1 chk("bc_release_ready", 64'(in_ready), 64'h1);
        step();
        in_valid = 1'b0; bcast = 1'b0;
        chk("bc_all_valid", 64'(out_valid), 64'hFF);
        chk("bc_all_data", out_data, 64'h7777_7777_7777_7777);
        chk("bc_all_last", 64'(out_last), 64'hFF);
        step();
        chk("bc_drained", 64'(out_valid), 64'h0);

        // Reset while locked with slot 4 full
        out_ready = 8'hEF;
        sel = 3'd4; in_data = 8'h88; in_last = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("mrst_pre_busy", 64'(busy), 64'h1);
        chk("mrst_pre_valid", 64'(out_valid), 64'h10);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mrst_valid", 64'(out_valid), 64'h0);
        chk("mrst_busy", 64'(busy), 64'h0);
        chk("mrst_cur_sel", 64'(cur_sel), 64'h0);
        chk("mrst_drop_cnt", 64'(drop_cnt), 64'h0);
        out_ready = 8'hFF;
        step();
        chk("mrst_no_delivery", 64'(out_valid), 64'h0);

        // Six-channel instance: dropped two-beat packet still locks the route
        b_sel = 3'd7; b_in_data = 8'hC0; b_in_last = 1'b0; b_in_valid = 1'b1;
        #1 chk("drop_pkt_ready0", 64'(b_in_ready), 64'h1);
        step();
        chk("drop_pkt_busy", 64'(b_busy), 64'h1);
        chk("drop_pkt_cur_sel", 64'(b_cur_sel), 64'h7);
        chk("drop_pkt_cnt1", 64'(b_drop_cnt), 64'h1);
        b_sel = 3'd1; b_in_data = 8'hC1; b_in_last = 1'b1;
        #1 chk("drop_pkt_ready1", 64'(b_in_ready), 64'h1);
        step();
        chk("drop_pkt_idle", 64'(b_busy), 64'h0);
        chk("drop_pkt_cnt2", 64'(b_drop_cnt), 64'h2);
        chk("drop_pkt_no_valid", 64'(b_out_valid), 64'h0);

        // 298 more single-beat packets to sel=7: counter saturates at 255
        b_sel = 3'd7;
        for (int k = 3; k <= 300; k++) begin
            b_in_data = 8'(k);
            #1 chk("drop_ready", 64'(b_in_ready), 64'h1);
            step();
            chk("drop_no_valid", 64'(b_out_valid), 64'h0);
            if (k == 100) chk("drop_cnt_100", 64'(b_drop_cnt), 64'd100);
            if (k == 255) chk("drop_cnt_255", 64'(b_drop_cnt), 64'd255);
        end
        b_in_valid = 1'b0;
        chk("drop_cnt_sat", 64'(b_drop_cnt), 64'd255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
